// File: rtl/micro_sequencer_pkg.sv
// Shared widths, opcode and state encodings for the microcode sequencer.
package micro_sequencer_pkg;

    localparam int unsigned ADDR_W      = 6;
    localparam int unsigned C_W         = 6;
    localparam int unsigned T_W         = 7;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned SP_W        = 3;
    localparam int unsigned IDX_W       = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NEXT = 3'b000,
        OP_JUMP = 3'b001,
        OP_BRZ  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_HALT = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    // Microcode word layout: {op, T, C}
    typedef struct packed {
        op_e            op;
        logic [T_W-1:0] t;
        logic [C_W-1:0] c;
    } uword_t;

endpackage

// File: rtl/micro_stack.sv
// Four-entry return-address stack; callers must not push when full or pop when empty.
module micro_stack
    import micro_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top
);

    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [IDX_W-1:0]  top_idx;

    // Occupancy flags and top-of-stack read
    always_comb begin
        full    = (sp_q == SP_W'(STACK_DEPTH));
        empty   = (sp_q == '0);
        top_idx = IDX_W'(sp_q - SP_W'(1));
        top     = mem_q[top_idx];
    end

    // Next stack pointer; clear wins over push/pop
    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    // Stack pointer register
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents are unreachable after reset so they are not cleared
    always_ff @(posedge clock) begin
        if (push && !full && !clear && !reset) begin
            mem_q[sp_q[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: fetches from an external ROM, resolves flow control and
// drives registered C/T fields to the next pipeline stage.
module micro_sequencer
    import micro_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stall,
    input  logic              cond,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [C_W-1:0]    C_out,
    output logic [T_W-1:0]    T_out,
    output logic              valid_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [C_W-1:0]    c_q, c_d;
    logic [T_W-1:0]    t_q, t_d;
    logic              valid_q, valid_d;

    uword_t            word;
    logic [ADDR_W-1:0] upc_inc;
    logic              stk_clear;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;

    assign word    = uword_t'(rom_data);
    assign upc_inc = upc_q + ADDR_W'(1);

    micro_stack u_stack (
        .clock     (clock),
        .reset     (reset),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (upc_inc),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    // Next-state, program counter, stack control and output field decode
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        c_d       = c_q;
        t_d       = t_q;
        valid_d   = valid_q;
        stk_clear = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                c_d     = '0;
                t_d     = '0;
                valid_d = 1'b0;
                if (start) begin
                    upc_d     = start_addr;
                    stk_clear = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    c_d     = '0;
                    t_d     = '0;
                    valid_d = 1'b0;
                    case (word.op)
                        OP_JUMP: upc_d = word.c;
                        OP_BRZ:  upc_d = cond ? upc_inc : word.c;
                        OP_CALL: begin
                            if (stk_full) begin
                                state_d = ST_ERROR;
                            end else begin
                                stk_push = 1'b1;
                                upc_d    = word.c;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                state_d = ST_ERROR;
                            end else begin
                                stk_pop = 1'b1;
                                upc_d   = stk_top;
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: begin
                            c_d     = word.c;
                            t_d     = word.t;
                            valid_d = 1'b1;
                            upc_d   = upc_inc;
                        end
                    endcase
                end
            end
            default: begin
                c_d     = '0;
                t_d     = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, program counter and pipeline output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            c_q     <= '0;
            t_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            c_q     <= c_d;
            t_q     <= t_d;
            valid_q <= valid_d;
        end
    end

    // Status flags are pure state decodes
    always_comb begin
        rom_addr  = upc_q;
        C_out     = c_q;
        T_out     = t_q;
        valid_out = valid_q;
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_HALT);
        error     = (state_q == ST_ERROR);
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have these ports, one line each as: name, direction, width, meaning.
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins execution at start_addr; honoured only in IDLE or HALT.
REQ-005 start_addr  in  6  first microinstruction address.
REQ-006 stall  in  1  downstream pipeline hold request.
REQ-007 cond  in  1  branch condition for BRZ, sampled in the decode cycle.
REQ-008 rom_addr  out  6  combinational microcode ROM address; equals upc.
REQ-009 rom_data  in  16  combinational ROM word {op[15:13], T[12:6], C[5:0]}.
REQ-010 C_out  out  6  registered control field to pipeline stage.
REQ-011 T_out  out  7  registered T field to pipeline stage.
REQ-012 valid_out  out  1  C_out/T_out carry a real microinstruction.
REQ-013 busy  out  1  state is RUN.
REQ-014 done  out  1  state is HALT.
REQ-015 error  out  1  state is ERROR.

Function
REQ-016 States SHALL be IDLE, RUN, HALT, ERROR; busy/done/error SHALL be decoded from state only.
REQ-017 IDLE or HALT with start=1 SHALL load upc<=start_addr, clear sp, and go to RUN next cycle.
REQ-018 start in RUN or ERROR SHALL be ignored.
REQ-019 In RUN with stall=1, upc, sp, stack, C_out, T_out and valid_out SHALL hold; no op is decoded.
REQ-020 In RUN with stall=0, the op from rom_data SHALL be decoded once per cycle.
REQ-021 op 000 NEXT: C_out<=C, T_out<=T, valid_out<=1, upc<=upc+1 (mod 64, 63 wraps to 0).
REQ-022 op 001 JUMP: upc<=C field; emit a bubble.
REQ-023 op 010 BRZ: if cond=0, upc<=C field, else upc<=upc+1 mod 64; emit a bubble.
REQ-024 op 011 CALL: push (upc+1) mod 64, upc<=C field; emit a bubble.
REQ-025 op 100 RET: upc<=popped address; emit a bubble.
REQ-026 op 101 HALT: go to HALT; emit a bubble; upc holds.
REQ-027 ops 110/111 SHALL behave as NEXT.
REQ-028 A bubble SHALL mean C_out<=0, T_out<=0, valid_out<=0.
REQ-029 Return stack depth SHALL be 4 entries of 6 bits; sp ranges 0..4.
REQ-030 CALL with sp=4 (overflow) or RET with sp=0 (underflow) SHALL go to ERROR with a bubble; stack and upc unchanged.
REQ-031 ERROR SHALL be sticky until reset.
REQ-032 In IDLE, HALT and ERROR, valid_out SHALL be 0 and C_out/T_out SHALL be 0 from the cycle after entry.
REQ-033 Latency: a NEXT word at rom_addr appears on C_out/T_out exactly one cycle later when stall=0.
REQ-034 Outside RUN, stall SHALL have no effect.

Reset
REQ-035 reset=1 SHALL override all other inputs, including stall, start and a mid-RUN CALL/RET.
REQ-036 Reset values SHALL be: state=IDLE, upc=0, sp=0, C_out=0, T_out=0, valid_out=0, busy=0, done=0, error=0.
REQ-037 Stack entry contents need not be reset; sp=0 makes them unreachable.

Structure
REQ-038 A shared package SHALL hold the widths (C=6, T=7, addr=6, word=16), op encodings, stack depth and state encoding.
REQ-039 The return stack SHALL be a sub-module micro_stack (push, pop, full, empty, top; synchronous reset of pointer).

Verification
REQ-040 start_addr=5; ROM[5]=NEXT C=0x2A T=0x11; ROM[6]=HALT -> C_out=0x2A, T_out=0x11, valid_out=1 one cycle after RUN entry; then a bubble; done=1.
REQ-041 Run at upc=63 with ROM[63]=NEXT -> next rom_addr=0.
REQ-042 stall=1 for 3 cycles mid-run -> rom_addr and outputs are frozen; the sequence resumes unchanged afterward.
REQ-043 BRZ target 0x10: cond=0 -> rom_addr=0x10; cond=1 -> rom_addr=upc+1.
REQ-044 CALL 0x20 at addr 3 with ROM[0x20]=RET -> rom_addr goes 3, 0x20, 4; five nested CALLs -> error=1 on the fifth; RET at sp=0 -> error=1.
REQ-045 reset asserted during RUN with stall=1 -> all REQ-036 values in the next cycle; a following start pulse runs normally.
